// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative low-half multiplier built on the shared ALU's ADD.
// Shift-and-add, one multiplier bit per cycle, stopping early once the
// remaining multiplier bits are all zero. Operands arrive and the product
// leaves through valid/ready handshakes.
module alu_mul_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0]         CNT_INIT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD  = OPCODE_LENGTH'(4'b0010);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   accept_s;
  logic                   last_bit_s;

  // The iteration after this one would see no set multiplier bits, or the
  // bit budget is spent: either way this is the final RUN cycle.
  function automatic logic is_last_step(input logic [DATA_WIDTH-1:0] mplier,
                                        input logic [CNT_W-1:0]      cnt);
    logic upper_zero;
    upper_zero   = (mplier[DATA_WIDTH-1:1] == {(DATA_WIDTH-1){1'b0}});
    is_last_step = upper_zero || (cnt == CNT_ONE);
  endfunction

  assign accept_s   = req_valid && (state_q == ST_IDLE);
  assign last_bit_s = is_last_step(mplier_q, cnt_q);

  // State register: async clear drops any in-flight multiply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last bit,
  // DONE -> IDLE on consume (never straight back into RUN).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready  = 1'b1;
      end
      ST_RUN: begin
        busy       = 1'b1;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  // Datapath next values: load operands on accept, shift-and-add in RUN,
  // hold everything otherwise so the result stays stable under backpressure.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          acc_d    = {DATA_WIDTH{1'b0}};
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = CNT_INIT;
        end else begin
          acc_d    = acc_q;
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) begin
          acc_d = alu_result;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = {mcand_q[DATA_WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[DATA_WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_ONE;
      end
      ST_DONE: begin
        acc_d = acc_q;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= {DATA_WIDTH{1'b0}};
      mcand_q  <= {DATA_WIDTH{1'b0}};
      mplier_q <= {DATA_WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // The ALU is always driven with acc + mcand; its sum is only taken in RUN.
  assign alu_srca      = acc_q;
  assign alu_srcb      = mcand_q;
  assign alu_operation = ALU_ADD;
  assign result        = acc_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed multiplies checked against a transaction
// level model (product, latency from the multiplier's top bit) every cycle,
// plus hand-computed literal results.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  // The shared ALU, doing what it does for ADD.
  assign alu_result = alu_srca + alu_srcb;

  alu_mul_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .result        (result),
    .busy          (busy),
    .alu_srca      (alu_srca),
    .alu_srcb      (alu_srcb),
    .alu_operation (alu_operation),
    .alu_result    (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of RUN cycles: position of the highest set multiplier bit, at least 1.
  function automatic int kof(input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) k = i + 1;
    end
    return k;
  endfunction

  // Model: phase 0 idle, 1 computing, 2 result offered.
  int          mdl_phase;
  int          mdl_rem;
  logic [31:0] mdl_prod;
  logic [31:0] mdl_mc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_phase <= 0;
      mdl_rem   <= 0;
      mdl_prod  <= 32'd0;
      mdl_mc    <= 32'd0;
    end else begin
      case (mdl_phase)
        0: if (req_valid) begin
          mdl_phase <= 1;
          mdl_rem   <= kof(op_b);
          mdl_prod  <= op_a * op_b;
          mdl_mc    <= op_a << kof(op_b);
        end
        1: if (mdl_rem == 1) mdl_phase <= 2;
           else mdl_rem <= mdl_rem - 1;
        2: if (resp_ready) mdl_phase <= 0;
        default: mdl_phase <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("req_ready", {31'd0, req_ready},  {31'd0, mdl_phase == 0});
      check("busy",      {31'd0, busy},       {31'd0, mdl_phase != 0});
      check("resp_valid",{31'd0, resp_valid}, {31'd0, mdl_phase == 2});
      check("alu_op",    {28'd0, alu_operation}, 32'h2);
      if (mdl_phase == 2) check("result", result, mdl_prod);
      if (mdl_phase != 1) begin
        check("alu_srca", alu_srca, mdl_prod);
        check("alu_srcb", alu_srcb, mdl_mc);
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    op_a = a;
    op_b = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic [31:0] exp_res,
                           input int exp_k, input int hold);
    int n;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_k));
    check({tag, "_result"}, result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_result"}, result, exp_res);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    op_a       = 32'd0;
    op_b       = 32'd0;
    #2;
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_result",     result,              32'd0);
    check("rst_srca",       alu_srca,            32'd0);
    check("rst_srcb",       alu_srcb,            32'd0);
    check("rst_alu_op",     {28'd0, alu_operation}, 32'h2);
    // Pin the model's latency rule to hand-derived values.
    check("k_of_0",   32'(kof(32'd0)),          32'd1);
    check("k_of_1",   32'(kof(32'd1)),          32'd1);
    check("k_of_5",   32'(kof(32'd5)),          32'd3);
    check("k_of_msb", 32'(kof(32'h8000_0000)),  32'd32);
    #20;
    reset_n = 1'b1;
    @(posedge clk); #1;

    start(32'd7, 32'd5);
    wait_resp("mul7x5", 32'd35, 3, 0);
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("wrap_ff", 32'h0000_0001, 32, 0);
    start(32'h8000_0000, 32'd2);
    wait_resp("wrap_msb", 32'h0000_0000, 2, 0);
    start(32'h1234_5678, 32'd0);
    wait_resp("zero_b", 32'd0, 1, 0);
    start(32'd3, 32'd4);
    wait_resp("backpr", 32'd12, 3, 5);

    // A 9x9 request held during 6x6 must wait until IDLE.
    start(32'd6, 32'd6);
    op_a = 32'd9;
    op_b = 32'd9;
    req_valid = 1'b1;
    wait_resp("busy6x6", 32'd36, 3, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy9_taken", {31'd0, busy}, 32'd1);
    wait_resp("mul9x9", 32'd81, 4, 0);

    // Asynchronous reset in the third RUN cycle of 0xFF x 0xFF.
    start(32'hFF, 32'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_busy",       {31'd0, busy},       32'd0);
    check("mrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mrst_srca",       alu_srca,            32'd0);
    check("mrst_req_ready",  {31'd0, req_ready},  32'd1);
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_no_stale", {31'd0, resp_valid}, 32'd0);
    start(32'd2, 32'd3);
    wait_resp("mul2x3", 32'd6, 2, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative multiply sequencer that computes the low DATA_WIDTH bits of A×B by time-multiplexing the shared ALU's ADD operation. It uses a shift-and-add algorithm and terminates early once the remaining multiplier bits are zero. It sits beside the ALU in the execute stage. It owns the ALU operand and operation inputs only while a multiply is running, and exchanges operands and results with the core through valid/ready handshakes.

## Interface
- DATA_WIDTH, 32, operand, result and ALU width
- OPCODE_LENGTH, 4, ALU operation code width
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  multiply request valid
- req_ready  out  1  sequencer can accept a request
- op_a  in  DATA_WIDTH  multiplicand
- op_b  in  DATA_WIDTH  multiplier
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  product, low DATA_WIDTH bits
- busy  out  1  high in RUN or DONE
- alu_srca  out  DATA_WIDTH  ALU SrcA
- alu_srcb  out  DATA_WIDTH  ALU SrcB
- alu_operation  out  OPCODE_LENGTH  ALU Operation; constant 4'b0010 (ADD)
- alu_result  in  DATA_WIDTH  ALU ALUResult, combinational

## Operation
- Registers:
  - acc (DATA_WIDTH)
  - mcand (DATA_WIDTH)
  - mplier (DATA_WIDTH)
  - cnt (ceil(log2(DATA_WIDTH))+1 bits)
  - state: IDLE, RUN or DONE
- ALU drive: alu_srca = acc, alu_srcb = mcand, alu_operation = 4'b0010 in every state. The outputs are combinational from the registers.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: acc <= 0, mcand <= op_a, mplier <= op_b, cnt <= DATA_WIDTH, and the state moves to RUN.
- RUN, one multiplier bit per cycle:
  - If mplier[0], acc <= alu_result (acc + mcand, wrapping mod 2^DATA_WIDTH); otherwise acc holds.
  - mcand <= mcand << 1 (zero fill).
  - mplier <= mplier >> 1 (logical).
  - cnt <= cnt - 1.
- RUN exit: move to DONE when (mplier >> 1) == 0 or cnt == 1. Otherwise stay in RUN.
- DONE:
  - resp_valid = 1 and result = acc.
  - On resp_ready, return to IDLE.
  - result and acc must be held stable while resp_valid && !resp_ready.
- result equals acc in all states. It is only meaningful while resp_valid = 1.
- Signedness: the low-half product is identical for signed and unsigned operands, so there is no sign handling.
- Requests while busy: req_ready = 0 and req_valid is ignored. The bench must not see op_a or op_b sampled outside IDLE.
- A new request is never accepted in the same cycle a response is consumed. DONE → IDLE → accept takes at least one IDLE cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - Registers clear immediately: state = IDLE, acc = mcand = mplier = 0, cnt = 0.
  - The in-flight operation is discarded and no response is issued.

## Timing
- Reset values of outputs:
  - req_ready = 1
  - resp_valid = 0
  - busy = 0
  - result = 0
  - alu_srca = 0
  - alu_srcb = 0
  - alu_operation = 4'b0010
- Latency: request accepted at edge T; RUN occupies k cycles; resp_valid is first high in cycle T+1+k.
  - k = max(1, msb_index(op_b) + 1).
  - op_b = 0 or 1 gives k = 1.
  - op_b = 0x8000_0000 gives k = 32.
  - k never exceeds DATA_WIDTH.
- Throughput: k + 2 cycles minimum per multiply (RUN k, DONE ≥ 1, IDLE 1).
- The ALU path is combinational within one cycle: alu_srca/alu_srcb to alu_result to the acc D-input. There are no registers on the ALU interface.
- Handshakes follow standard valid/ready:
  - A transfer occurs on the edge where valid && ready.
  - resp_valid, once high, stays high until the transfer.

## Test plan
- Basic multiply: op_a = 7, op_b = 5.
  - RUN lasts 3 cycles; resp_valid is high in cycle T+4.
  - result = 35; req_ready = 0 for cycles T+1 through T+4.
- Wrap-around: op_a = 0xFFFF_FFFF, op_b = 0xFFFF_FFFF.
  - 32 RUN cycles; resp_valid in cycle T+33; result = 0x0000_0001.
  - Also check op_a = 0x8000_0000, op_b = 2, which gives result = 0.
- Zero multiplier: op_a = 0x1234_5678, op_b = 0.
  - One RUN cycle with acc unchanged; resp_valid in cycle T+2; result = 0.
- Backpressure: op_a = 3, op_b = 4, with resp_ready held low for 5 cycles after resp_valid rises.
  - resp_valid stays at 1 and result stays at 12 throughout.
  - Returns to IDLE on the edge after resp_ready rises.
- Busy rejection: during RUN of 6×6, pulse req_valid with op_a = 9, op_b = 9.
  - The pulse is ignored; result = 36.
  - The next request, 9×9, is accepted only from IDLE and gives 81.
- Mid-operation reset: assert reset_n = 0 asynchronously in the 3rd RUN cycle of 0xFF×0xFF.
  - Immediately: busy = 0, resp_valid = 0, alu_srca = 0.
  - After release, a 2×3 request returns 6 with no stale response beforehand.
